// File: rtl/moving_avg_pkg.sv
// Shared types for the multi-channel moving-average custom instruction:
// command opcodes, datab field positions and controller states.
package moving_avg_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_READ  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_COUNT = 2'b11
  } op_e;

  localparam int OP_LSB = 0;
  localparam int OP_W   = 2;
  localparam int CH_LSB = 4;
  localparam int CH_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_UPDATE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/moving_avg_sample_ram.sv
// Sample history store: simple dual-port, registered read, no reset so it
// maps onto block RAM.
module moving_avg_sample_ram #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/moving_avg_multi_ci.sv
// Multi-channel moving-average engine on the Nios II custom-instruction port.
// Running sums are updated incrementally: add newest sample, drop the oldest.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | wait for start; latch op/ch/sample; PUSH presents RAM addr
//   ST_FETCH  | oldest sample returning from the registered RAM read
//   ST_UPDATE | update sum/ptr/count, write new sample into the window
//   ST_RESP   | register result, pulse done, back to idle
module moving_avg_multi_ci
  import moving_avg_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 4,
  parameter int NUM_CH     = 4,
  parameter int SIGNED     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W    = DATA_W + LOG2_DEPTH;
  localparam int CNT_W    = LOG2_DEPTH + 1;
  localparam int ADDR_W   = CH_IDX_W + LOG2_DEPTH;
  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic             IS_SIGNED = (SIGNED != 0);

  state_e                state;
  op_e                   op_r;
  logic [CH_IDX_W-1:0]   ch_r;
  logic [DATA_W-1:0]     sample_r;

  logic [SUM_W-1:0]      sum_q [NUM_CH];
  logic [LOG2_DEPTH-1:0] ptr_q [NUM_CH];
  logic [CNT_W-1:0]      cnt_q [NUM_CH];

  logic [CH_W-1:0]       ch_raw;
  logic                  ch_ok;
  logic [CH_IDX_W-1:0]   ch_sel;
  op_e                   op_sel;

  logic [DATA_W-1:0]     ram_q;
  logic [DATA_W-1:0]     oldest;
  logic [SUM_W-1:0]      oldest_x;
  logic [SUM_W-1:0]      sample_x;
  logic [SUM_W-1:0]      sum_next;
  logic [DATA_W-1:0]     avg;
  logic [31:0]           avg_x;
  logic [ADDR_W-1:0]     raddr;
  logic [ADDR_W-1:0]     waddr;
  logic                  ram_we;
  logic                  unused_bits;

  // Out-of-range channels fall back to a harmless READ of channel 0.
  assign ch_raw = datab[CH_LSB +: CH_W];
  assign ch_ok  = {1'b0, ch_raw} < NUM_CH_L;
  assign ch_sel = ch_ok ? ch_raw[CH_IDX_W-1:0] : '0;
  assign op_sel = ch_ok ? op_e'(datab[OP_LSB +: OP_W]) : OP_READ;

  // RAM contents are ignored until the window has been filled once.
  assign oldest   = (cnt_q[ch_r] == CNT_FULL) ? ram_q : '0;
  assign oldest_x = {{LOG2_DEPTH{IS_SIGNED & oldest[DATA_W-1]}}, oldest};
  assign sample_x = {{LOG2_DEPTH{IS_SIGNED & sample_r[DATA_W-1]}}, sample_r};
  assign sum_next = sum_q[ch_r] - oldest_x + sample_x;

  assign avg   = sum_q[ch_r][SUM_W-1:LOG2_DEPTH];
  assign avg_x = {{(32-DATA_W){IS_SIGNED & avg[DATA_W-1]}}, avg};

  // ptr only moves in UPDATE, so the latched address keeps ram_q stable.
  assign raddr  = (state == ST_IDLE) ? {ch_sel, ptr_q[ch_sel]} : {ch_r, ptr_q[ch_r]};
  assign waddr  = {ch_r, ptr_q[ch_r]};
  assign ram_we = (state == ST_UPDATE) && !reset;

  assign unused_bits = ^{dataa[31:DATA_W], datab[31:CH_LSB+CH_W],
                         datab[CH_LSB-1:OP_LSB+OP_W]};

  moving_avg_sample_ram #(
    .DATA_W (DATA_W),
    .WORDS  (NUM_CH * (1 << LOG2_DEPTH)),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (clk_en),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (sample_r),
    .raddr (raddr),
    .q     (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      done     <= 1'b0;
      op_r     <= OP_PUSH;
      ch_r     <= '0;
      sample_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c] <= '0;
        ptr_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r     <= op_sel;
            ch_r     <= ch_sel;
            sample_r <= dataa[DATA_W-1:0];
            state    <= (op_sel == OP_PUSH) ? ST_FETCH : ST_RESP;
          end
        end
        ST_FETCH: state <= ST_UPDATE;
        ST_UPDATE: begin
          sum_q[ch_r] <= sum_next;
          ptr_q[ch_r] <= ptr_q[ch_r] + 1'b1;
          if (cnt_q[ch_r] != CNT_FULL) cnt_q[ch_r] <= cnt_q[ch_r] + 1'b1;
          state <= ST_RESP;
        end
        ST_RESP: begin
          done  <= 1'b1;
          state <= ST_IDLE;
          case (op_r)
            OP_COUNT: result <= {{(32-CNT_W){1'b0}}, cnt_q[ch_r]};
            OP_CLEAR: begin
              result      <= '0;
              sum_q[ch_r] <= '0;
              ptr_q[ch_r] <= '0;
              cnt_q[ch_r] <= '0;
            end
            default:  result <= avg_x;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_moving_avg_multi_ci.sv
// Scoreboard bench: unsigned and signed instances share stimulus; a window
// model predicts each response and a monitor compares on every done pulse.
`timescale 1ns/1ps
module tb_moving_avg_multi_ci;

  localparam logic [1:0] PUSH = 2'b00, READ = 2'b01, CLEAR = 2'b10, COUNT = 2'b11;

  logic        clk, reset, clk_en, start;
  logic [31:0] dataa, datab;
  logic [31:0] result_u, result_s;
  logic        done_u, done_s;

  int checks = 0;
  int errors = 0;

  logic [15:0] hist [4][$];
  logic [31:0] exp_u [$];
  logic [31:0] exp_s [$];

  moving_avg_multi_ci #(.DATA_W(16), .LOG2_DEPTH(4), .NUM_CH(4), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .result(result_u), .done(done_u));

  moving_avg_multi_ci #(.DATA_W(16), .LOG2_DEPTH(4), .NUM_CH(4), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .result(result_s), .done(done_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) hist[c].delete();
  endfunction

  // Window average with implicit zeros: divisor is always 16.
  function automatic logic [31:0] avg_u(input int c);
    int s = 0;
    for (int i = 0; i < hist[c].size(); i++) s += int'(hist[c][i]);
    return 32'(s / 16);
  endfunction

  function automatic logic [31:0] avg_s(input int c);
    int s = 0;
    int q;
    for (int i = 0; i < hist[c].size(); i++) s += int'($signed(hist[c][i]));
    q = s / 16;
    if ((s % 16) != 0 && s < 0) q = q - 1;
    return 32'(q);
  endfunction

  function automatic void model_cmd(input logic [1:0] op, input int ch, input logic [15:0] d);
    if (ch >= 4) begin
      op = READ;
      ch = 0;
    end
    case (op)
      PUSH: begin
        hist[ch].push_back(d);
        if (hist[ch].size() > 16) void'(hist[ch].pop_front());
        exp_u.push_back(avg_u(ch));
        exp_s.push_back(avg_s(ch));
      end
      READ: begin
        exp_u.push_back(avg_u(ch));
        exp_s.push_back(avg_s(ch));
      end
      CLEAR: begin
        hist[ch].delete();
        exp_u.push_back(32'h0);
        exp_s.push_back(32'h0);
      end
      default: begin
        exp_u.push_back(32'(hist[ch].size()));
        exp_s.push_back(32'(hist[ch].size()));
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (done_u) begin
      checks++;
      if (exp_u.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done_u: got done with result 0x%08h, required no done", result_u);
      end else begin
        logic [31:0] e;
        e = exp_u.pop_front();
        if (result_u !== e) begin
          errors++;
          $display("FAIL result_u: got 0x%08h expected 0x%08h", result_u, e);
        end
      end
    end
    if (done_s) begin
      checks++;
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done_s: got done with result 0x%08h, required no done", result_s);
      end else begin
        logic [31:0] e;
        e = exp_s.pop_front();
        if (result_s !== e) begin
          errors++;
          $display("FAIL result_s: got 0x%08h expected 0x%08h", result_s, e);
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns during the done cycle.
  task automatic cmd(input logic [1:0] op, input int ch, input logic [15:0] d,
                     input int stall, input bit spurious,
                     output logic [31:0] ru, output logic [31:0] rs);
    int n;
    int exp_lat;
    bit got;
    logic [1:0] eop;
    eop = (ch >= 4) ? READ : op;
    exp_lat = ((eop == PUSH) ? 3 : 1) + stall;
    model_cmd(op, ch, d);
    dataa = {16'($urandom), d};
    datab = $urandom;
    datab[7:4] = 4'(ch);
    datab[1:0] = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (stall > 0) clk_en = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (n == stall) clk_en = 1'b1;
      if (spurious && n == 1) begin
        datab = {24'h0, 4'd2, 4'(READ)};
        start = 1'b1;
      end
      if (spurious && n == 2) start = 1'b0;
      if (done_u) got = 1'b1;
    end
    clk_en = 1'b1;
    start = 1'b0;
    chk("latency", 32'(n), got ? 32'(exp_lat) : 32'hFFFF_FFFF);
    chk("done_s_aligned", {31'h0, done_s}, 32'h1);
    ru = result_u;
    rs = result_s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] ru, rs;
    int          ch, gap;
    logic [1:0]  op;
    logic [15:0] d;

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = '0; datab = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("reset_result_u", result_u, 32'h0);
    chk("reset_done_u", {31'h0, done_u}, 32'h0);
    chk("reset_result_s", result_s, 32'h0);
    chk("reset_done_s", {31'h0, done_s}, 32'h0);

    for (int k = 1; k <= 16; k++) begin
      cmd(PUSH, 0, 16'h0010, 0, 0, ru, rs);
      chk("warmup_avg", ru, 32'(k));
    end
    cmd(COUNT, 0, 16'h0, 0, 0, ru, rs);
    chk("warmup_count", ru, 32'd16);

    for (int k = 0; k < 16; k++) cmd(PUSH, 3, 16'h0100, 0, 0, ru, rs);
    chk("wrap_full", ru, 32'h100);
    cmd(PUSH, 3, 16'h0000, 0, 0, ru, rs);
    chk("wrap_first_drop", ru, 32'hF0);
    for (int k = 0; k < 15; k++) cmd(PUSH, 3, 16'h0000, 0, 0, ru, rs);
    chk("wrap_drained", ru, 32'h0);
    cmd(COUNT, 3, 16'h0, 0, 0, ru, rs);
    chk("wrap_count_sat", ru, 32'd16);

    for (int k = 0; k < 16; k++) cmd(PUSH, 1, 16'h0008, 0, 0, ru, rs);
    for (int k = 0; k < 16; k++) cmd(PUSH, 2, 16'h0040, 0, 0, ru, rs);
    cmd(CLEAR, 1, 16'h0, 0, 0, ru, rs);
    chk("clear_result", ru, 32'h0);
    cmd(READ, 1, 16'h0, 0, 0, ru, rs);
    chk("clear_read", ru, 32'h0);
    cmd(COUNT, 1, 16'h0, 0, 0, ru, rs);
    chk("clear_count", ru, 32'h0);
    cmd(READ, 2, 16'h0, 0, 0, ru, rs);
    chk("isolation_read", ru, 32'h40);

    cmd(PUSH, 2, 16'h0040, 5, 0, ru, rs);
    chk("stall_value", ru, 32'h40);
    cmd(PUSH, 2, 16'h0040, 0, 1, ru, rs);
    repeat (4) begin @(posedge clk); #1; end

    dataa = 32'h0000_1234;
    datab = {24'h0, 4'd0, 4'(PUSH)};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_result_u", result_u, 32'h0);
    chk("abort_done_u", {31'h0, done_u}, 32'h0);
    chk("abort_result_s", result_s, 32'h0);
    cmd(PUSH, 0, 16'h0020, 0, 0, ru, rs);
    chk("after_abort_push", ru, 32'h2);

    do_reset();
    cmd(PUSH, 0, 16'hFFFF, 0, 0, ru, rs);
    chk("signed_floor", rs, 32'hFFFF_FFFF);
    chk("unsigned_ffff", ru, 32'h0000_0FFF);
    for (int k = 0; k < 16; k++) cmd(PUSH, 3, 16'hFFF0, 0, 0, ru, rs);
    chk("signed_full", rs, 32'hFFFF_FFF0);

    for (int t = 0; t < 400; t++) begin
      op = ($urandom_range(0, 9) < 5) ? PUSH : 2'($urandom_range(1, 3));
      ch = $urandom_range(0, 5);
      d  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF)) : 16'($urandom);
      cmd(op, ch, d, ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0, 0, ru, rs);
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end

    for (int w = 0; w < 10 && (exp_u.size() != 0 || exp_s.size() != 0); w++) @(posedge clk);
    #1;
    chk("drain_u", 32'(exp_u.size()), 32'h0);
    chk("drain_s", 32'(exp_s.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
